uart_rate_cmd_rx: RTL and testbench

UART receive and command-decode stage driving the 2-bit rate select of the LED clock divider in the UART/SEG/PWM/LED design. It deserialises 8-bit frames from the host serial line at a fixed baud rate derived from the 100 MHz system clock. It maps ASCII commands '0'..'3' onto a registered rate code consumed directly by the divider's rate-control input.

---
 rtl/uart_rate_pkg.sv | 20 ++
 rtl/uart_rx_core.sv | 78 +++++++
 rtl/uart_rate_cmd_rx.sv | 55 +++++
 tb/tb_uart_rate_cmd_rx.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/uart_rate_pkg.sv
// uart_rate_pkg: shared FSM states, command bytes and rate codes for the UART rate-command receiver.
package uart_rate_pkg;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } rxState_t;
  localparam logic [7:0] CMD_RATE0 = 8'h30;
  localparam logic [7:0] CMD_RATE1 = 8'h31;
  localparam logic [7:0] CMD_RATE2 = 8'h32;
  localparam logic [7:0] CMD_RATE3 = 8'h33;
  localparam logic [1:0] RATE_1    = 2'b00;
  localparam logic [1:0] RATE_5    = 2'b01;
  localparam logic [1:0] RATE_10   = 2'b10;
  localparam logic [1:0] RATE_OFF  = 2'b11;
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 (8E1 with UART_PARITY_EN) deserialiser; strobes byte/valid/frame-error on the stop sample.
module uart_rx_core
  import uart_rate_pkg::*;
#(
  parameter int CLOCKFREQ    = 100_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLOCKFREQ / BAUD
) (
  input  logic       iClk,
  input  logic       iRSt_n,
  input  logic       iRx,
  output logic [7:0] oByte,
  output logic       oValid,
  output logic       oFrameErr
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  rxState_t state, stateNxt;
  logic rxMeta, rxS, rxD, tick;
  logic [CW-1:0] cnt;
  logic [2:0] bitIdx;
  logic [7:0] shReg;
`ifdef UART_PARITY_EN
  logic parErr;
`endif
  assign tick  = cnt == ((state == START) ? HALF : FULL);
  assign oByte = shReg;
  always_ff @(posedge iClk or negedge iRSt_n) begin
    if (!iRSt_n) begin
      {rxD, rxS, rxMeta} <= 3'b111;
      state  <= IDLE;
      cnt    <= '0;
      bitIdx <= '0;
      shReg  <= '0;
`ifdef UART_PARITY_EN
      parErr <= 1'b0;
`endif
    end else begin
      {rxD, rxS, rxMeta} <= {rxS, rxMeta, iRx};
      state <= stateNxt;
      cnt   <= (state == IDLE || stateNxt != state || tick) ? '0 : cnt + 1'b1;
      if (state == DATA && tick) begin
        shReg  <= {rxS, shReg[7:1]};
        bitIdx <= bitIdx + 1'b1;
      end
`ifdef UART_PARITY_EN
      if (state == PARITY && tick) parErr <= ^shReg ^ rxS;
`endif
    end
  end
  always_comb begin
    stateNxt  = state;
    oValid    = 1'b0;
    oFrameErr = 1'b0;
    case (state)
      IDLE:   stateNxt = (rxD && !rxS) ? START : IDLE;
      START:  stateNxt = tick ? (rxS ? IDLE : DATA) : START;
`ifdef UART_PARITY_EN
      DATA:   stateNxt = (tick && bitIdx == 3'd7) ? PARITY : DATA;
      PARITY: stateNxt = tick ? STOP : PARITY;
      STOP: begin
        stateNxt  = tick ? IDLE : STOP;
        oValid    = tick && rxS && !parErr;
        oFrameErr = tick && !(rxS && !parErr);
      end
`else
      DATA:   stateNxt = (tick && bitIdx == 3'd7) ? STOP : DATA;
      STOP: begin
        stateNxt  = tick ? IDLE : STOP;
        oValid    = tick && rxS;
        oFrameErr = tick && !rxS;
      end
`endif
      default: stateNxt = IDLE;
    endcase
  end
endmodule

// File: rtl/uart_rate_cmd_rx.sv
// uart_rate_cmd_rx: UART receiver plus ASCII '0'..'3' decode into the divider rate code (8E1 with UART_PARITY_EN).
module uart_rate_cmd_rx
  import uart_rate_pkg::*;
#(
  parameter int CLOCKFREQ    = 100_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLOCKFREQ / BAUD
) (
  input  logic       iClk,
  input  logic       iRSt_n,
  input  logic       iRx,
  output logic [1:0] oRate_control,
  output logic       oRate_valid,
  output logic [7:0] oRxData,
  output logic       oRxValid,
  output logic       oFrameErr
);
  logic [7:0] rxByte;
  logic rxValid, rxErr, cmdHit;
  logic [1:0] cmdRate;
  uart_rx_core #(
    .CLOCKFREQ(CLOCKFREQ),
    .BAUD(BAUD),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uCore (
    .iClk(iClk),
    .iRSt_n(iRSt_n),
    .iRx(iRx),
    .oByte(rxByte),
    .oValid(rxValid),
    .oFrameErr(rxErr)
  );
  always_comb begin
    cmdHit  = rxValid && (rxByte == CMD_RATE0 || rxByte == CMD_RATE1 ||
                          rxByte == CMD_RATE2 || rxByte == CMD_RATE3);
    cmdRate = (rxByte == CMD_RATE0) ? RATE_1 :
              (rxByte == CMD_RATE1) ? RATE_5 :
              (rxByte == CMD_RATE2) ? RATE_10 : RATE_OFF;
  end
  always_ff @(posedge iClk or negedge iRSt_n) begin
    if (!iRSt_n) begin
      oRate_control <= RATE_1;
      oRate_valid   <= 1'b0;
      oRxData       <= '0;
      oRxValid      <= 1'b0;
      oFrameErr     <= 1'b0;
    end else begin
      oRxValid    <= rxValid;
      oFrameErr   <= rxErr;
      oRate_valid <= cmdHit;
      if (rxValid) oRxData <= rxByte;
      if (cmdHit) oRate_control <= cmdRate;
    end
  end
endmodule

// File: tb/tb_uart_rate_cmd_rx.sv
// tb_uart_rate_cmd_rx: directed frames with hand-computed results; define UART_PARITY_EN for the 8E1 build.
module tb_uart_rate_cmd_rx;
  localparam int CPB = 868;
`ifdef UART_PARITY_EN
  localparam int LAT = 9117;
`else
  localparam int LAT = 8249;
`endif
  logic iClk = 1'b0, iRSt_n = 1'b0, iRx = 1'b1;
  logic [1:0] oRate_control;
  logic [7:0] oRxData;
  logic oRate_valid, oRxValid, oFrameErr;
  int cyc = 0, t0 = 0, nChk = 0, nErr = 0;
  int nRx = 0, nRate = 0, nFe = 0, nBoth = 0, rxCyc = 0, rateCyc = 0, feCyc = 0;
  int sRx, sRate, sFe;
  uart_rate_cmd_rx dut (
    .iClk(iClk), .iRSt_n(iRSt_n), .iRx(iRx),
    .oRate_control(oRate_control), .oRate_valid(oRate_valid),
    .oRxData(oRxData), .oRxValid(oRxValid), .oFrameErr(oFrameErr)
  );
  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;
  always @(negedge iClk) begin
    if (oRxValid) begin nRx++; rxCyc = cyc; end
    if (oRate_valid) begin nRate++; rateCyc = cyc; end
    if (oFrameErr) begin nFe++; feCyc = cyc; end
    if (oRxValid && oFrameErr) nBoth++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChk++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic snap();
    sRx = nRx; sRate = nRate; sFe = nFe;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge iClk);
  endtask
  // Called right after a negedge; abortAfter > 0 releases the line high mid-frame.
  task automatic sendByte(input logic [7:0] b, input logic stopBit, input logic parFlip, input int abortAfter);
    logic [10:0] bits;
    int n;
`ifdef UART_PARITY_EN
    bits = {stopBit, ^b ^ parFlip, b, 1'b0};
    n = 11;
`else
    bits = {1'b1, stopBit, b, 1'b0};
    n = 10;
    if (parFlip) n = 10;
`endif
    t0 = cyc;
    for (int i = 0; i < n; i++) begin
      iRx = bits[i];
      for (int j = 0; j < CPB; j++) begin
        if (abortAfter > 0 && i * CPB + j >= abortAfter) begin
          iRx = 1'b1;
          return;
        end
        @(negedge iClk);
      end
    end
    iRx = 1'b1;
  endtask
  initial begin
    idle(5);
    chk("rst_rate", oRate_control, 2'b00);
    chk("rst_data", oRxData, 8'h00);
    chk("rst_rxvalid", oRxValid, 1'b0);
    chk("rst_ratevalid", oRate_valid, 1'b0);
    chk("rst_frameerr", oFrameErr, 1'b0);
    iRSt_n = 1'b1;
    idle(5);
    snap();
    sendByte(8'h32, 1'b1, 1'b0, 0);
    idle(10);
    chk("b32_rxvalid_cnt", nRx - sRx, 1);
    chk("b32_ratevalid_cnt", nRate - sRate, 1);
    chk("b32_latency", rxCyc - t0, LAT);
    chk("b32_rate_same_cycle", rateCyc, rxCyc);
    chk("b32_data", oRxData, 8'h32);
    chk("b32_rate", oRate_control, 2'b10);
    chk("b32_frameerr_cnt", nFe - sFe, 0);
    snap();
    sendByte(8'h41, 1'b1, 1'b0, 0);
    idle(10);
    chk("b41_rxvalid_cnt", nRx - sRx, 1);
    chk("b41_ratevalid_cnt", nRate - sRate, 0);
    chk("b41_data", oRxData, 8'h41);
    chk("b41_rate", oRate_control, 2'b10);
    snap();
    sendByte(8'h31, 1'b0, 1'b0, 0);
    idle(10);
    chk("stop0_frameerr_cnt", nFe - sFe, 1);
    chk("stop0_latency", feCyc - t0, LAT);
    chk("stop0_rxvalid_cnt", nRx - sRx, 0);
    chk("stop0_ratevalid_cnt", nRate - sRate, 0);
    chk("stop0_data", oRxData, 8'h41);
    chk("stop0_rate", oRate_control, 2'b10);
    snap();
    iRx = 1'b0;
    idle(200);
    iRx = 1'b1;
    idle(240);
    chk("glitch_rxvalid_cnt", nRx - sRx, 0);
    chk("glitch_frameerr_cnt", nFe - sFe, 0);
    chk("glitch_ratevalid_cnt", nRate - sRate, 0);
    sendByte(8'h33, 1'b1, 1'b0, 0);
    idle(10);
    chk("post_glitch_rxvalid_cnt", nRx - sRx, 1);
    chk("post_glitch_latency", rxCyc - t0, LAT);
    chk("post_glitch_data", oRxData, 8'h33);
    chk("post_glitch_rate", oRate_control, 2'b11);
    snap();
    fork
      sendByte(8'h33, 1'b1, 1'b0, CPB * 5 + 400);
      begin
        idle(CPB * 5 + 200);
        iRSt_n = 1'b0;
        idle(3);
        chk("midrst_rate", oRate_control, 2'b00);
        chk("midrst_data", oRxData, 8'h00);
        chk("midrst_rxvalid", oRxValid, 1'b0);
        chk("midrst_ratevalid", oRate_valid, 1'b0);
        iRSt_n = 1'b1;
      end
    join
    idle(2000);
    chk("midrst_rxvalid_cnt", nRx - sRx, 0);
    chk("midrst_frameerr_cnt", nFe - sFe, 0);
    snap();
    sendByte(8'h30, 1'b1, 1'b0, 0);
    idle(10);
    chk("b30_rxvalid_cnt", nRx - sRx, 1);
    chk("b30_ratevalid_cnt", nRate - sRate, 1);
    chk("b30_data", oRxData, 8'h30);
    chk("b30_rate", oRate_control, 2'b00);
`ifdef UART_PARITY_EN
    snap();
    sendByte(8'h33, 1'b1, 1'b1, 0);
    idle(10);
    chk("badpar_frameerr_cnt", nFe - sFe, 1);
    chk("badpar_latency", feCyc - t0, LAT);
    chk("badpar_rxvalid_cnt", nRx - sRx, 0);
    chk("badpar_rate", oRate_control, 2'b00);
    chk("badpar_data", oRxData, 8'h30);
    snap();
    sendByte(8'h33, 1'b1, 1'b0, 0);
    idle(10);
    chk("goodpar_rxvalid_cnt", nRx - sRx, 1);
    chk("goodpar_rate", oRate_control, 2'b11);
`endif
    chk("valid_err_overlap", nBoth, 0);
    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end
endmodule
